// File: rtl/ft245a_device.sv
// rtl/ft245a_device.sv - FTDI-side model of the FT245 async FIFO protocol
//
// Purpose: answers RD#/WR# strobes from an FT245 async master, driving RXF#,
// TXE# and read data, and bridges the transfers to two internal buffers that
// face the host side as valid/ready streams.
//
// Ports:
//   ft_clk, ft_rstn      clock, synchronous active-low reset
//   ft_rdn, ft_wrn       RD#/WR# from master (asynchronous, synchronized here)
//   ft_din               data from master on writes
//   ft_dout, ft_oe       read data and its drive enable
//   ft_rxfn, ft_txen     RXF# (0 = data to read), TXE# (0 = space to write)
//   h2f_data/valid/ready host -> master stream into the H2F buffer
//   f2h_data/valid/ready master -> host stream out of the F2H buffer
//   h2f_count, f2h_count buffer occupancies
//   proto_err            sticky protocol violation flag
module ft245a_device #(
   parameter int DATA_W         = 8,
   parameter int H2F_DEPTH      = 16,
   parameter int F2H_DEPTH      = 16,
   parameter int RECOVERY_TICKS = 4
) (
   input  logic                         ft_clk,
   input  logic                         ft_rstn,
   input  logic                         ft_rdn,
   input  logic                         ft_wrn,
   input  logic [DATA_W-1:0]            ft_din,
   output logic [DATA_W-1:0]            ft_dout,
   output logic                         ft_oe,
   output logic                         ft_rxfn,
   output logic                         ft_txen,
   input  logic [DATA_W-1:0]            h2f_data,
   input  logic                         h2f_valid,
   output logic                         h2f_ready,
   output logic [DATA_W-1:0]            f2h_data,
   output logic                         f2h_valid,
   input  logic                         f2h_ready,
   output logic [$clog2(H2F_DEPTH):0]   h2f_count,
   output logic [$clog2(F2H_DEPTH):0]   f2h_count,
   output logic                         proto_err
);

   localparam int HAW = $clog2(H2F_DEPTH);
   localparam int FAW = $clog2(F2H_DEPTH);
   localparam int CW  = $clog2(RECOVERY_TICKS) + 1;
   localparam logic [CW-1:0] RECOVER_LOAD = CW'(RECOVERY_TICKS - 1);

   localparam logic [1:0] R_IDLE    = 2'd0;
   localparam logic [1:0] R_ACTIVE  = 2'd1;
   localparam logic [1:0] R_RECOVER = 2'd2;
   localparam logic [1:0] W_IDLE    = 2'd0;
   localparam logic [1:0] W_ACTIVE  = 2'd1;
   localparam logic [1:0] W_RECOVER = 2'd2;

   // ---------------- input synchronizers ----------------
   logic              rd_s1, rd_s2, rd_s3;
   logic              wr_s1, wr_s2, wr_s3;
   logic [DATA_W-1:0] din_s1, din_s2, wr_data;
   logic              rst_done, rd_arm, wr_arm;

   always_ff @(posedge ft_clk) begin
      if (!ft_rstn) begin
         rd_s1    <= 1'b1;
         rd_s2    <= 1'b1;
         rd_s3    <= 1'b1;
         wr_s1    <= 1'b1;
         wr_s2    <= 1'b1;
         wr_s3    <= 1'b1;
         din_s1   <= '0;
         din_s2   <= '0;
         wr_data  <= '0;
         rst_done <= 1'b0;
         rd_arm   <= 1'b0;
         wr_arm   <= 1'b0;
      end else begin
         rd_s1    <= ft_rdn;
         rd_s2    <= rd_s1;
         rd_s3    <= rd_s2;
         wr_s1    <= ft_wrn;
         wr_s2    <= wr_s1;
         wr_s3    <= wr_s2;
         din_s1   <= ft_din;
         din_s2   <= din_s1;
         rst_done <= 1'b1;
         // A strobe held through reset must be seen high along the whole
         // sync pipe (with stage 1 holding a real pin sample) before any of
         // its edges are acted on.
         rd_arm   <= rd_arm | (rst_done & rd_s1 & rd_s2 & rd_s3);
         wr_arm   <= wr_arm | (rst_done & wr_s1 & wr_s2 & wr_s3);
         // Latest data sample taken while WR# was still low.
         if (!wr_s2)
            wr_data <= din_s2;
      end
   end

   logic rd_fall, rd_rise, wr_fall, wr_rise, both_low;
   assign rd_fall  = rd_arm & rd_s3 & ~rd_s2;
   assign rd_rise  = rd_arm & ~rd_s3 & rd_s2;
   assign wr_fall  = wr_arm & wr_s3 & ~wr_s2;
   assign wr_rise  = wr_arm & ~wr_s3 & wr_s2;
   assign both_low = rd_arm & wr_arm & ~rd_s2 & ~wr_s2;

   // ---------------- H2F buffer ----------------
   logic [DATA_W-1:0] h_mem [H2F_DEPTH];
   logic [HAW:0]      h_wptr, h_rptr;
   logic              h_empty, h_full, h_push, h_pop;

   assign h_empty   = (h_wptr == h_rptr);
   assign h_full    = (h_wptr[HAW] != h_rptr[HAW]) &&
                      (h_wptr[HAW-1:0] == h_rptr[HAW-1:0]);
   assign h2f_ready = ~h_full;
   assign h2f_count = h_wptr - h_rptr;
   assign h_push    = h2f_valid & h2f_ready;

   always_ff @(posedge ft_clk) begin
      if (h_push)
         h_mem[h_wptr[HAW-1:0]] <= h2f_data;
   end

   always_ff @(posedge ft_clk) begin
      if (!ft_rstn) begin
         h_wptr <= '0;
         h_rptr <= '0;
      end else begin
         if (h_push) h_wptr <= h_wptr + 1'b1;
         if (h_pop)  h_rptr <= h_rptr + 1'b1;
      end
   end

   // ---------------- F2H buffer with registered head ----------------
   logic [DATA_W-1:0] f_mem [F2H_DEPTH];
   logic [FAW:0]      f_wptr, f_rptr, f_rnext, f_left;
   logic              f_full, f_push, f_pop;

   assign f_full    = (f_wptr[FAW] != f_rptr[FAW]) &&
                      (f_wptr[FAW-1:0] == f_rptr[FAW-1:0]);
   assign f2h_count = f_wptr - f_rptr;
   assign f_pop     = f2h_valid & f2h_ready;
   assign f_rnext   = f_rptr + {{FAW{1'b0}}, f_pop};
   // Words already stored that remain after this cycle's pop; a word pushed
   // this cycle appears at the head one cycle later.
   assign f_left    = f2h_count - {{FAW{1'b0}}, f_pop};

   always_ff @(posedge ft_clk) begin
      if (f_push)
         f_mem[f_wptr[FAW-1:0]] <= wr_data;
   end

   always_ff @(posedge ft_clk) begin
      if (!ft_rstn) begin
         f_wptr    <= '0;
         f_rptr    <= '0;
         f2h_valid <= 1'b0;
         f2h_data  <= '0;
      end else begin
         if (f_push) f_wptr <= f_wptr + 1'b1;
         f_rptr    <= f_rnext;
         f2h_valid <= (f_left != '0);
         f2h_data  <= f_mem[f_rnext[FAW-1:0]];
      end
   end

   // ---------------- read FSM ----------------
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;

   assign ft_rxfn = (r_state == R_IDLE) ? h_empty : (r_state == R_RECOVER);
   assign h_pop   = (r_state == R_IDLE) & rd_fall & ~ft_rxfn & ~both_low;

   always_ff @(posedge ft_clk) begin
      if (!ft_rstn) begin
         r_state <= R_IDLE;
         r_cnt   <= '0;
         ft_dout <= '0;
         ft_oe   <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (h_pop) begin
                  ft_dout <= h_mem[h_rptr[HAW-1:0]];
                  ft_oe   <= 1'b1;
                  r_state <= R_ACTIVE;
               end
            end
            R_ACTIVE: begin
               if (rd_rise) begin
                  ft_oe   <= 1'b0;
                  r_cnt   <= RECOVER_LOAD;
                  r_state <= R_RECOVER;
               end
            end
            R_RECOVER: begin
               if (r_cnt == '0) r_state <= R_IDLE;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // ---------------- write FSM ----------------
   logic [1:0]    w_state;
   logic [CW-1:0] w_cnt;
   logic          w_start;

   assign ft_txen = (w_state == W_IDLE) ? f_full : (w_state == W_RECOVER);
   assign w_start = (w_state == W_IDLE) & wr_fall & ~ft_txen & ~both_low;
   assign f_push  = (w_state == W_ACTIVE) & wr_rise;

   always_ff @(posedge ft_clk) begin
      if (!ft_rstn) begin
         w_state <= W_IDLE;
         w_cnt   <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (w_start) w_state <= W_ACTIVE;
            end
            W_ACTIVE: begin
               if (wr_rise) begin
                  w_cnt   <= RECOVER_LOAD;
                  w_state <= W_RECOVER;
               end
            end
            W_RECOVER: begin
               if (w_cnt == '0) w_state <= W_IDLE;
               else             w_cnt   <= w_cnt - 1'b1;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // ---------------- protocol violations ----------------
   always_ff @(posedge ft_clk) begin
      if (!ft_rstn)
         proto_err <= 1'b0;
      else if (both_low | (rd_fall & ft_rxfn) | (wr_fall & ft_txen))
         proto_err <= 1'b1;
   end

endmodule

// File: tb/tb_ft245a_device.sv
// tb/tb_ft245a_device.sv - randomized self-checking bench for ft245a_device
module tb_ft245a_device;

   localparam int DEPTH = 16;
   localparam int RT    = 4;

   logic       clk = 1'b0;
   logic       rstn, rdn, wrn, h_valid, f_ready;
   logic [7:0] din, dout, h_data, f_data;
   logic       oe, rxfn, txen, h_ready, f_valid, err;
   logic [4:0] h_count, f_count;

   int tests = 0;
   int fails = 0;

   logic [7:0] h_model[$];
   logic [7:0] f_model[$];

   always #5 clk = ~clk;

   ft245a_device #(.DATA_W(8), .H2F_DEPTH(DEPTH), .F2H_DEPTH(DEPTH), .RECOVERY_TICKS(RT)) dut (
      .ft_clk(clk), .ft_rstn(rstn), .ft_rdn(rdn), .ft_wrn(wrn), .ft_din(din),
      .ft_dout(dout), .ft_oe(oe), .ft_rxfn(rxfn), .ft_txen(txen),
      .h2f_data(h_data), .h2f_valid(h_valid), .h2f_ready(h_ready),
      .f2h_data(f_data), .f2h_valid(f_valid), .f2h_ready(f_ready),
      .h2f_count(h_count), .f2h_count(f_count), .proto_err(err));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_push(input logic [7:0] d);
      bit space;
      space = (h_model.size() < DEPTH);
      check("h2f_ready_before_push", 32'(h_ready), 32'(space));
      h_valid = 1'b1;
      h_data  = d;
      tick();
      h_valid = 1'b0;
      if (space) h_model.push_back(d);
      check("h2f_count_after_push", 32'(h_count), 32'(h_model.size()));
      check("rxfn_after_push", 32'(rxfn), 32'(0));
   endtask

   task automatic master_read(input bit push_at_pop, input logic [7:0] pd);
      logic [7:0] exp;
      exp = h_model.pop_front();
      check("rxfn_before_read", 32'(rxfn), 32'(0));
      rdn = 1'b0;
      tick();
      tick();
      check("oe_not_yet", 32'(oe), 32'(0));
      if (push_at_pop) begin
         h_valid = 1'b1;
         h_data  = pd;
         h_model.push_back(pd);
      end
      tick();
      h_valid = 1'b0;
      check("oe_read", 32'(oe), 32'(1));
      check("dout_read", 32'(dout), 32'(exp));
      check("h2f_count_after_pop", 32'(h_count), 32'(h_model.size()));
      tick();
      rdn = 1'b1;
      tick();
      tick();
      check("oe_held", 32'(oe), 32'(1));
      tick();
      check("oe_released", 32'(oe), 32'(0));
      for (int i = 0; i < RT; i++) begin
         check("rxfn_recovery", 32'(rxfn), 32'(1));
         tick();
      end
      check("rxfn_after_recovery", 32'(rxfn), 32'(h_model.size() == 0));
   endtask

   task automatic master_write(input logic [7:0] d);
      check("txen_before_write", 32'(txen), 32'(0));
      din = d;
      wrn = 1'b0;
      repeat (4) tick();
      wrn = 1'b1;
      tick();
      tick();
      check("txen_not_yet", 32'(txen), 32'(0));
      check("f2h_count_not_yet", 32'(f_count), 32'(f_model.size()));
      tick();
      f_model.push_back(d);
      check("f2h_count_after_write", 32'(f_count), 32'(f_model.size()));
      for (int i = 0; i < RT; i++) begin
         check("txen_recovery", 32'(txen), 32'(1));
         tick();
      end
      check("txen_after_recovery", 32'(txen), 32'(f_model.size() == DEPTH));
      tick();
      din = 8'($urandom);
   endtask

   task automatic host_pop_one();
      check("f2h_valid_head", 32'(f_valid), 32'(1));
      check("f2h_data_head", 32'(f_data), 32'(f_model[0]));
      f_ready = 1'b1;
      tick();
      f_ready = 1'b0;
      void'(f_model.pop_front());
      check("f2h_count_after_pop", 32'(f_count), 32'(f_model.size()));
   endtask

   task automatic drain_f2h();
      int budget;
      budget = 400;
      while (f_model.size() > 0 && budget > 0) begin
         f_ready = 1'($urandom_range(0, 1));
         if (f_valid && f_ready) begin
            check("f2h_drain_data", 32'(f_data), 32'(f_model[0]));
            void'(f_model.pop_front());
         end
         tick();
         budget--;
      end
      f_ready = 1'b0;
      check("f2h_drain_left", 32'(f_model.size()), 32'(0));
      tick();
      check("f2h_count_drained", 32'(f_count), 32'(0));
      check("f2h_valid_drained", 32'(f_valid), 32'(0));
      check("txen_drained", 32'(txen), 32'(0));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_dout"}, 32'(dout), 32'(0));
      check({tag, "_oe"}, 32'(oe), 32'(0));
      check({tag, "_rxfn"}, 32'(rxfn), 32'(1));
      check({tag, "_txen"}, 32'(txen), 32'(0));
      check({tag, "_h2f_ready"}, 32'(h_ready), 32'(1));
      check({tag, "_f2h_valid"}, 32'(f_valid), 32'(0));
      check({tag, "_h2f_count"}, 32'(h_count), 32'(0));
      check({tag, "_f2h_count"}, 32'(f_count), 32'(0));
      check({tag, "_proto_err"}, 32'(err), 32'(0));
   endtask

   initial begin
      rstn = 1'b0; rdn = 1'b1; wrn = 1'b1; din = '0;
      h_valid = 1'b0; h_data = '0; f_ready = 1'b0;
      repeat (3) tick();
      rstn = 1'b1;
      repeat (3) tick();
      check_reset_values("reset");

      // single byte host -> master
      host_push(8'h5A);
      master_read(1'b0, 8'h00);

      // master fills F2H with 0x00..0x0F, then host drains it
      for (int i = 0; i < DEPTH; i++) master_write(8'(i));
      repeat (3) tick();
      check("txen_full", 32'(txen), 32'(1));
      check("f2h_count_full", 32'(f_count), 32'(DEPTH));
      drain_f2h();

      // fill H2F, offer one extra word, read all back
      for (int i = 0; i < DEPTH; i++) host_push(8'($urandom));
      check("h2f_ready_full", 32'(h_ready), 32'(0));
      host_push(8'($urandom));
      for (int i = 0; i < DEPTH; i++) master_read(1'b0, 8'h00);
      check("rxfn_empty_end", 32'(rxfn), 32'(1));

      // host push coinciding with master pop keeps the count
      for (int i = 0; i < 3; i++) host_push(8'($urandom));
      master_read(1'b1, 8'($urandom));
      check("h2f_count_simul", 32'(h_count), 32'(3));

      // random mix of all four transfer kinds
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0: if (h_model.size() < DEPTH) host_push(8'($urandom));
            1: if (h_model.size() > 0) master_read(1'b0, 8'h00);
            2: if (f_model.size() < DEPTH) master_write(8'($urandom));
            default: if (f_model.size() > 0) host_pop_one();
         endcase
      end
      while (h_model.size() > 0) master_read(1'b0, 8'h00);
      drain_f2h();

      // RD# with nothing to read
      check("err_clear_before", 32'(err), 32'(0));
      rdn = 1'b0;
      repeat (3) tick();
      check("err_rd_empty", 32'(err), 32'(1));
      check("oe_rd_empty", 32'(oe), 32'(0));
      check("h2f_count_rd_empty", 32'(h_count), 32'(0));
      tick();
      rdn = 1'b1;
      repeat (10) tick();
      check("err_sticky", 32'(err), 32'(1));
      check("rxfn_rd_empty", 32'(rxfn), 32'(1));

      // reset while a read is active, RD# held low across reset
      host_push(8'($urandom));
      host_push(8'($urandom));
      rdn = 1'b0;
      repeat (3) tick();
      check("oe_before_reset", 32'(oe), 32'(1));
      rstn = 1'b0;
      tick();
      check_reset_values("midreset");
      h_model.delete();
      f_model.delete();
      rstn = 1'b1;
      repeat (4) tick();
      rdn = 1'b1;
      repeat (8) tick();
      check("err_after_reset_strobe", 32'(err), 32'(0));
      check("oe_after_reset_strobe", 32'(oe), 32'(0));
      host_push(8'hC3);
      master_read(1'b0, 8'h00);
      master_write(8'h3C);
      drain_f2h();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/ft245a_device.md
# ft245a_device

Synthesizable model of the FTDI chip side of the FT245-style asynchronous FIFO protocol. It drives RXF#/TXE#/data and responds to RD#/WR# from an FT245 async master. It bridges those transfers to two internal FIFOs with valid/ready streams on the host side. It is used for on-FPGA loopback and for hardware-in-the-loop regression of the master without an FTDI part. A single clock domain samples all protocol inputs through 2-FF synchronizers.

## Interface
Parameters:
- DATA_W, 8, protocol data bus width
- H2F_DEPTH, 16, host→FPGA buffer depth in words (power of 2, ≥2)
- F2H_DEPTH, 16, FPGA→host buffer depth in words (power of 2, ≥2)
- RECOVERY_TICKS, 4, cycles RXF#/TXE# are held inactive after a transfer completes (≥1)

Ports:
- ft_clk  in  1  clock; all logic on its rising edge
- ft_rstn  in  1  synchronous, active-low reset
- ft_rdn  in  1  RD# from master
- ft_wrn  in  1  WR# from master
- ft_din  in  DATA_W  data from master (write)
- ft_dout  out  DATA_W  data to master (read)
- ft_oe  out  1  data bus drive enable (1 = drive ft_dout)
- ft_rxfn  out  1  RXF#, 0 = data available to read
- ft_txen  out  1  TXE#, 0 = space available to write
- h2f_data  in  DATA_W  host data destined for master
- h2f_valid  in  1  h2f_data valid
- h2f_ready  out  1  H2F buffer not full
- f2h_data  out  DATA_W  data written by master
- f2h_valid  out  1  f2h_data valid
- f2h_ready  in  1  consumer accepts f2h_data
- h2f_count  out  $clog2(H2F_DEPTH)+1  H2F occupancy
- f2h_count  out  $clog2(F2H_DEPTH)+1  F2H occupancy
- proto_err  out  1  sticky protocol violation flag

## Operation
- Input sync: ft_rdn, ft_wrn pass through 2 flops, reset to 1. ft_din passes through a parallel 2-flop pipe, reset to 0. Edges are detected on the 2nd stage against a 3rd delay flop.
- H2F buffer: push on h2f_valid&&h2f_ready. Pop on a synced RD# falling edge while RXF# is 0. Full/empty are derived from ptrs with an extra wrap bit.
- F2H buffer: push on a synced WR# rising edge while TXE# is 0. Pop on f2h_valid&&f2h_ready. f2h_data/f2h_valid come from a registered head (first-word fall-through).
- Read FSM:
  - R_IDLE: ft_rxfn = h2f empty. A RD# falling edge with ft_rxfn=0 pops the head into ft_dout, sets ft_oe=1 and goes to R_ACTIVE.
  - R_ACTIVE: on a RD# rising edge, ft_oe=0, ft_rxfn=1, load the counter with RECOVERY_TICKS-1 and go to R_RECOVER.
  - R_RECOVER: ft_rxfn=1. When the counter reaches 0, go to R_IDLE.
- Write FSM:
  - W_IDLE: ft_txen = f2h full. A WR# falling edge with ft_txen=0 goes to W_ACTIVE.
  - W_ACTIVE: on a WR# rising edge, push the 2nd-stage din sample (the last sample taken while WR# was low), set ft_txen=1 and go to W_RECOVER.
  - W_RECOVER: ft_txen=1 for RECOVERY_TICKS cycles, then go to W_IDLE.
- Violations set proto_err until reset. The offending access has no effect: no pop, no push, FSM stays idle. Violations are:
  - RD# falls while ft_rxfn=1
  - WR# falls while ft_txen=1
  - RD# and WR# are both low on the same synced cycle
- Simultaneous host push and master pop (or master push and host pop) in one cycle is legal. The count is unchanged in that case.

## Timing
- Reset values: ft_dout=0, ft_oe=0, ft_rxfn=1, ft_txen=0 (F2H empty), h2f_ready=1, f2h_valid=0, counts=0, proto_err=0, FSMs idle.
- ft_rxfn falls 1 cycle after the first push into an empty H2F buffer.
- RD# fall at raw cycle t produces ft_dout/ft_oe valid at t+3. RD# rise at t produces ft_oe=0 and ft_rxfn=1 at t+3.
- WR# rise at t produces ft_txen=1 and the push at t+3. f2h_valid rises 1 cycle later if the buffer was empty.
- Deasserted ft_rxfn/ft_txen stay high for exactly RECOVERY_TICKS cycles, then reflect buffer status.
- A master's minimum RD#/WR# active time is 4 ft_clk cycles.
- Reset mid-transfer: all state returns to reset values and buffer contents are discarded. The next RD#/WR# edge is ignored until the synced level matches.

## Test plan
- Reset, push 0x5A via h2f -> ft_rxfn=0 one cycle later; RD# low 4 cycles -> ft_dout=0x5A, ft_oe=1 3 cycles after fall; after rise, ft_rxfn=1 for 4 cycles, then 1 (empty).
- Master writes 0x00..0x0F (WR# low 4, high 8) with f2h_ready=0 -> ft_txen stays 1 after 16th write, f2h_count=16; release ready -> 0x00..0x0F in order, ft_txen returns 0.
- Fill H2F with 16 words -> h2f_ready=0; 17th offered word not accepted; master reads 16 -> values match, wrap exercised, ft_rxfn=1 at end.
- RD# pulse with H2F empty -> proto_err=1, ft_oe stays 0, h2f_count unchanged; stays set until ft_rstn=0.
- Host push and master read in same cycle with h2f_count=3 -> h2f_count stays 3; assert ft_rstn=0 during R_ACTIVE -> all outputs to reset values next cycle.
